// File: rtl/cpu_controller.sv
// cpu_controller: instruction register, field decoder and multi-cycle Moore
// control FSM for the 16-bit RISC CPU. Sequences the datapath plus the
// top-level PC / address / memory-command controls.
//
// Ports:
//   clk, reset_n          - clock, synchronous active-low reset
//   read_data[15:0]       - memory read bus, captured into IR on load_ir
//   writenum, readnum     - datapath register numbers
//   write, loada, loadb, loadc, loads, asel, bsel, vsel, shift, ALUop
//                         - datapath controls
//   sximm5, sximm8        - sign-extended IR immediates
//   load_ir, load_pc, reset_pc, load_addr, addr_sel, mem_cmd
//                         - top-level fetch/address/memory controls
//   halted                - high while in HALT
module cpu_controller (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] read_data,
  output logic [2:0]  writenum,
  output logic [2:0]  readnum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output logic        load_ir,
  output logic        load_pc,
  output logic        reset_pc,
  output logic        load_addr,
  output logic        addr_sel,
  output logic [1:0]  mem_cmd,
  output logic        halted
);

  localparam int unsigned IR_W = 16;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPDPC, S_DECODE,
    S_WIMM, S_GETA, S_GETB, S_EXEC, S_WRITE,
    S_ADDR, S_LADDR, S_MEMRD, S_LWRITE, S_SOUT, S_MEMWR,
    S_HALT
  } state_t;

  state_t          state, state_next;
  logic [IR_W-1:0] ir;

  // IR field extraction
  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic       is_ldr, is_str, is_mov_reg;

  assign opcode     = ir[15:13];
  assign op         = ir[12:11];
  assign rn         = ir[10:8];
  assign rd         = ir[7:5];
  assign sh         = ir[4:3];
  assign rm         = ir[2:0];
  assign is_ldr     = (opcode == 3'b011);
  assign is_str     = (opcode == 3'b100);
  assign is_mov_reg = ({opcode, op} == 5'b110_00);

  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

  // Instruction register
  always_ff @(posedge clk) begin
    if (!reset_n)     ir <= '0;
    else if (load_ir) ir <= read_data;
  end

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_RST;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_RST:    state_next = S_IF1;
      S_IF1:    state_next = S_IF2;
      S_IF2:    state_next = S_UPDPC;
      S_UPDPC:  state_next = S_DECODE;
      S_DECODE: begin
        case ({opcode, op})
          5'b110_10:                   state_next = S_WIMM;
          5'b110_00, 5'b101_11:        state_next = S_GETB;
          5'b101_00, 5'b101_01,
          5'b101_10, 5'b011_00,
          5'b100_00:                   state_next = S_GETA;
          default: state_next = (opcode == 3'b111) ? S_HALT : S_IF1;
        endcase
      end
      S_WIMM:   state_next = S_IF1;
      S_GETA:   state_next = (is_ldr || is_str) ? S_ADDR : S_GETB;
      S_GETB:   state_next = is_str ? S_SOUT : S_EXEC;
      S_EXEC:   state_next = ({opcode, op} == 5'b101_01) ? S_IF1 : S_WRITE;
      S_WRITE:  state_next = S_IF1;
      S_ADDR:   state_next = S_LADDR;
      S_LADDR:  state_next = is_ldr ? S_MEMRD : S_GETB;
      S_MEMRD:  state_next = S_LWRITE;
      S_LWRITE: state_next = S_IF1;
      S_SOUT:   state_next = S_MEMWR;
      S_MEMWR:  state_next = S_IF1;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_RST;
    endcase
  end

  // Moore output decode from state and IR
  always_comb begin
    readnum   = rn;
    writenum  = rn;
    shift     = sh;
    ALUop     = op;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    vsel      = 2'b00;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    load_addr = 1'b0;
    addr_sel  = 1'b0;
    mem_cmd   = MEM_NONE;
    halted    = 1'b0;
    case (state)
      S_RST: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
      end
      S_IF1: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
      end
      S_IF2: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
        load_ir  = 1'b1;
      end
      S_UPDPC: load_pc = 1'b1;
      S_WIMM: begin
        vsel     = 2'b10;
        writenum = rn;
        write    = 1'b1;
      end
      S_GETA: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GETB: begin
        readnum = is_str ? rd : rm;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        asel = is_mov_reg;
        if ({opcode, op} == 5'b101_01) loads = 1'b1;
        else                           loadc = 1'b1;
      end
      S_WRITE: begin
        writenum = rd;
        write    = 1'b1;
      end
      S_ADDR: begin
        shift = 2'b00;
        ALUop = 2'b00;
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_LADDR: load_addr = 1'b1;
      S_MEMRD: mem_cmd = MEM_READ;
      S_LWRITE: begin
        mem_cmd  = MEM_READ;
        vsel     = 2'b11;
        writenum = rd;
        write    = 1'b1;
      end
      S_SOUT: begin
        shift = 2'b00;
        ALUop = 2'b00;
        asel  = 1'b1;
        loadc = 1'b1;
      end
      S_MEMWR: mem_cmd = MEM_WRITE;
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed testbench for cpu_controller: steps instructions through fetch and
// execute, checking the Moore outputs of each state against hand-derived values.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] read_data;
  logic [2:0]  writenum, readnum;
  logic        write, loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm5, sximm8;
  logic        load_ir, load_pc, reset_pc, load_addr, addr_sel;
  logic [1:0]  mem_cmd;
  logic        halted;

  int checks = 0;
  int errors = 0;

  cpu_controller dut (
    .clk(clk), .reset_n(reset_n), .read_data(read_data),
    .writenum(writenum), .readnum(readnum),
    .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(ALUop),
    .sximm5(sximm5), .sximm8(sximm8),
    .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc),
    .load_addr(load_addr), .addr_sel(addr_sel), .mem_cmd(mem_cmd),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // IF1 signature: address from PC, read command, IR not yet loading
  task automatic chk_if1(input string tag);
    chk(tag, 16'({addr_sel, load_ir, mem_cmd}), 16'b1_0_01);
  endtask

  // From a sampled IF1: walk IF2, UPDPC, DECODE, leave sampled at cycle 5
  task automatic fetch(input logic [15:0] instr, input string tag);
    read_data = instr;
    step();
    chk({tag, "_if2"}, 16'({load_ir, addr_sel, mem_cmd}), 16'b1_1_01);
    step();
    chk({tag, "_updpc"}, 16'({load_pc, load_ir, mem_cmd}), 16'b1_0_00);
    step();
    chk({tag, "_decode"}, 16'({load_pc, load_ir, mem_cmd, write, addr_sel}), 16'b0);
    step();
  endtask

  initial begin
    reset_n   = 1'b0;
    read_data = 16'h0000;
    step();
    step();
    chk("rst_reset_pc", 16'(reset_pc), 16'd1);
    chk("rst_load_pc", 16'(load_pc), 16'd1);
    chk("rst_mem_cmd", 16'(mem_cmd), 16'd0);
    chk("rst_halted", 16'(halted), 16'd0);
    chk("rst_sximm8", sximm8, 16'h0000);
    chk("rst_nums", 16'({readnum, writenum}), 16'd0);
    reset_n = 1'b1;
    step();
    chk_if1("rst_to_if1");

    // MOV R0,#-8
    fetch(16'hD0F8, "movi");
    chk("movi_sximm8", sximm8, 16'hFFF8);
    chk("movi_vsel", 16'(vsel), 16'd2);
    chk("movi_writenum", 16'(writenum), 16'd0);
    chk("movi_write", 16'(write), 16'd1);
    step();
    chk_if1("movi_if1");

    // ADD R2,R1,R0,LSL#1
    fetch(16'hA148, "add");
    chk("add_geta", 16'({readnum, loada, loadb}), 16'b001_1_0);
    step();
    chk("add_getb", 16'({readnum, loadb, loada}), 16'b000_1_0);
    step();
    chk("add_exec", 16'({shift, ALUop, loadc, loads, asel, bsel}), 16'b01_00_1_0_0_0);
    step();
    chk("add_write", 16'({writenum, write, vsel}), 16'b010_1_00);
    step();
    chk_if1("add_if1");

    // CMP R0,R1
    fetch(16'hA801, "cmp");
    chk("cmp_geta", 16'({readnum, loada}), 16'b000_1);
    step();
    chk("cmp_getb", 16'({readnum, loadb}), 16'b001_1);
    step();
    chk("cmp_exec", 16'({loads, loadc, write, ALUop}), 16'b1_0_0_01);
    step();
    chk_if1("cmp_if1");

    // MOV R7,R1
    fetch(16'hC0E1, "movr");
    chk("movr_getb", 16'({readnum, loadb, loada}), 16'b001_1_0);
    step();
    chk("movr_exec", 16'({asel, bsel, loadc}), 16'b1_0_1);
    step();
    chk("movr_write", 16'({writenum, write}), 16'b111_1);
    step();
    chk_if1("movr_if1");

    // LDR R3,[R0,#-1]
    fetch(16'h607F, "ldr");
    chk("ldr_sximm5", sximm5, 16'hFFFF);
    chk("ldr_geta", 16'({readnum, loada}), 16'b000_1);
    step();
    chk("ldr_addr", 16'({bsel, asel, loadc, ALUop, shift}), 16'b1_0_1_00_00);
    step();
    chk("ldr_laddr", 16'({load_addr, mem_cmd}), 16'b1_00);
    step();
    chk("ldr_memrd", 16'({addr_sel, mem_cmd, write}), 16'b0_01_0);
    step();
    chk("ldr_lwrite", 16'({mem_cmd, vsel, writenum, write}), 16'b01_11_011_1);
    step();
    chk_if1("ldr_if1");

    // STR R3,[R1,#2]
    fetch(16'h8162, "str");
    chk("str_geta", 16'({readnum, loada}), 16'b001_1);
    step();
    chk("str_addr", 16'({bsel, loadc}), 16'b1_1);
    step();
    chk("str_laddr", 16'(load_addr), 16'd1);
    step();
    chk("str_getb", 16'({readnum, loadb}), 16'b011_1);
    step();
    chk("str_sout", 16'({asel, bsel, loadc, shift, mem_cmd}), 16'b1_0_1_00_00);
    step();
    chk("str_memwr", 16'({mem_cmd, addr_sel, write}), 16'b10_0_0);
    step();
    chk_if1("str_if1");

    // NOP (opcode 000): back to IF1 four cycles after IF1
    fetch(16'h0000, "nop");
    chk_if1("nop_if1");

    // Reset during EXEC of an ADD abandons the write
    fetch(16'hA148, "abort");
    step();
    step();
    chk("abort_exec", 16'(loadc), 16'd1);
    reset_n = 1'b0;
    step();
    chk("abort_rst", 16'({reset_pc, load_pc, write}), 16'b1_1_0);
    chk("abort_ir_clr", sximm8, 16'h0000);
    reset_n = 1'b1;
    step();
    chk_if1("abort_if1");

    // HALT holds with no memory traffic
    fetch(16'hE000, "halt");
    for (int i = 0; i < 20; i++) begin
      chk("halt_hold", 16'({halted, mem_cmd, write}), 16'b1_00_0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
